// File: rtl/mvau_inp_replay.sv
`default_nettype none
// ============================================================================
// Module   : mvau_inp_replay
// Purpose  : Ping-pong activation feeder for mvau_stream. Buffers one input
//            vector, then replays it once per neuron fold with weight addresses.
// Revision : 1.0 - initial release
// ============================================================================

module mvau_inp_replay #(
  parameter int MatrixW = 16,
  parameter int MatrixH = 16,
  parameter int SIMD    = 2,
  parameter int PE      = 2,
  parameter int TSrcI   = 4,
  localparam int SF         = MatrixW / SIMD,
  localparam int NF         = MatrixH / PE,
  localparam int WMEM_DEPTH = SF * NF,
  localparam int AW         = (WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_v,
  output logic                        s_rdy,
  input  logic [0:SIMD-1][TSrcI-1:0]  s_act,
  input  logic                        out_rdy,
  output logic                        in_v,
  output logic [0:SIMD-1][TSrcI-1:0]  in_act,
  output logic [AW-1:0]               wgt_addr,
  output logic                        vec_done
);

  localparam int SFW = (SF > 1) ? $clog2(SF) : 1;
  localparam int NFW = (NF > 1) ? $clog2(NF) : 1;
  localparam int DW  = SIMD * TSrcI;

  localparam logic [SFW-1:0] c_sf_last = SFW'(SF - 1);
  localparam logic [NFW-1:0] c_nf_last = NFW'(NF - 1);

  logic [DW-1:0]  r_buf [0:1][0:SF-1];

  logic [1:0]     r_full;
  logic           r_wr_bank;
  logic [SFW-1:0] r_wr_ptr;
  logic           r_rd_bank;
  logic [SFW-1:0] r_sf_cnt;
  logic [NFW-1:0] r_nf_cnt;

  logic           r_in_v;
  logic [DW-1:0]  r_in_act;
  logic [AW-1:0]  r_wgt_addr;
  logic           r_vec_done;

  logic           w_wr;
  logic           w_wr_last;
  logic           w_fire;
  logic           w_sf_last;
  logic           w_nf_last;
  logic           w_rd_last;
  logic [1:0]     w_set;
  logic [1:0]     w_clr;
  logic [AW-1:0]  w_addr;

  // Ready depends only on registered flags, so upstream never sees a loop.
  assign s_rdy     = ~r_full[r_wr_bank];
  assign w_wr      = s_v & s_rdy;
  assign w_wr_last = (r_wr_ptr == c_sf_last);

  assign w_fire    = r_full[r_rd_bank] & out_rdy;
  assign w_sf_last = (r_sf_cnt == c_sf_last);
  assign w_nf_last = (r_nf_cnt == c_nf_last);
  assign w_rd_last = w_fire & w_sf_last & w_nf_last;

  // Writer only touches an empty bank and the reader only a full one, so set
  // and clear can never target the same flag in one cycle.
  assign w_set = {2{w_wr & w_wr_last}} & {r_wr_bank, ~r_wr_bank};
  assign w_clr = {2{w_rd_last}}        & {r_rd_bank, ~r_rd_bank};

  assign w_addr = AW'(r_nf_cnt) * AW'(SF) + AW'(r_sf_cnt);

  // Buffer storage carries no reset; the flags alone qualify its contents.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_buf[r_wr_bank][r_wr_ptr] <= s_act;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 2'b00;
    end else begin
      r_full <= (r_full & ~w_clr) | w_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank <= 1'b0;
      r_wr_ptr  <= '0;
    end else if (w_wr) begin
      if (w_wr_last) begin
        r_wr_bank <= ~r_wr_bank;
        r_wr_ptr  <= '0;
      end else begin
        r_wr_ptr  <= r_wr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_bank <= 1'b0;
      r_sf_cnt  <= '0;
      r_nf_cnt  <= '0;
    end else if (w_fire) begin
      if (w_sf_last) begin
        r_sf_cnt <= '0;
        if (w_nf_last) begin
          r_nf_cnt  <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_nf_cnt  <= r_nf_cnt + 1'b1;
        end
      end else begin
        r_sf_cnt <= r_sf_cnt + 1'b1;
      end
    end
  end

  // Data and address hold across stalls; only the qualifiers drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_v     <= 1'b0;
      r_vec_done <= 1'b0;
      r_in_act   <= '0;
      r_wgt_addr <= '0;
    end else begin
      r_in_v     <= w_fire;
      r_vec_done <= w_rd_last;
      if (w_fire) begin
        r_in_act   <= r_buf[r_rd_bank][r_sf_cnt];
        r_wgt_addr <= w_addr;
      end
    end
  end

  assign in_v     = r_in_v;
  assign in_act   = r_in_act;
  assign wgt_addr = r_wgt_addr;
  assign vec_done = r_vec_done;

endmodule

`default_nettype wire

// File: tb/tb_mvau_inp_replay.sv
`default_nettype none
// ============================================================================
// Module   : tb_mvau_inp_replay
// Purpose  : Self-checking bench for mvau_inp_replay (SF=4, NF=2).
// Revision : 1.0 - initial release
// ============================================================================

module tb_mvau_inp_replay;

  localparam int MW   = 8;
  localparam int MH   = 4;
  localparam int SIMD = 2;
  localparam int PE   = 2;
  localparam int TS   = 4;
  localparam int SF   = MW / SIMD;
  localparam int NF   = MH / PE;
  localparam int AW   = 3;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    s_v = 1'b0;
  logic                    s_rdy;
  logic [0:SIMD-1][TS-1:0] s_act = '0;
  logic                    out_rdy = 1'b0;
  logic                    in_v;
  logic [0:SIMD-1][TS-1:0] in_act;
  logic [AW-1:0]           wgt_addr;
  logic                    vec_done;

  mvau_inp_replay #(
    .MatrixW (MW),
    .MatrixH (MH),
    .SIMD    (SIMD),
    .PE      (PE),
    .TSrcI   (TS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_v      (s_v),
    .s_rdy    (s_rdy),
    .s_act    (s_act),
    .out_rdy  (out_rdy),
    .in_v     (in_v),
    .in_act   (in_act),
    .wgt_addr (wgt_addr),
    .vec_done (vec_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus sources
  logic [7:0] send_q[$];
  int         sv_pct = 100;
  int         or_pct = 100;

  always @(negedge clk) begin
    if (rst_n && send_q.size() > 0 && $urandom_range(0, 99) < sv_pct) begin
      s_v   = 1'b1;
      s_act = send_q[0];
    end else begin
      s_v = 1'b0;
    end
    out_rdy = ($urandom_range(0, 99) < or_pct);
  end

  // Reference model: vectors of SF words, each expands to NF folds of SF beats.
  typedef struct {
    logic [7:0] act;
    int         addr;
    bit         done;
  } beat_t;

  logic [7:0] wbuf[$];
  beat_t      expq[$];
  int         pending = 0;
  int         cyc = 0;
  int         last_wr_cyc = 0;
  int         stall_cnt = 0;

  logic [7:0] log_act[$];
  int         log_addr[$];
  int         log_cyc[$];

  always @(posedge clk) begin : monitor
    bit         wr;
    bit         ors;
    int         pend;
    logic [7:0] wd;
    beat_t      b;
    cyc++;
    if (!rst_n) begin
      wbuf.delete();
      expq.delete();
      pending = 0;
    end else begin
      wr   = s_v && s_rdy;
      ors  = out_rdy;
      pend = pending;
      wd   = s_act;
      if (s_v && !s_rdy) stall_cnt++;
      if (wr && send_q.size() > 0) send_q.delete(0);
      #1;
      if (rst_n) begin
        if (wr) begin
          wbuf.push_back(wd);
          last_wr_cyc = cyc;
          if (wbuf.size() == SF) begin
            for (int nf = 0; nf < NF; nf++)
              for (int sf = 0; sf < SF; sf++)
                expq.push_back('{act: wbuf[sf], addr: nf * SF + sf,
                                 done: (nf == NF - 1 && sf == SF - 1)});
            wbuf.delete();
            pending++;
          end
        end
        check("in_v", in_v, (ors && pend > 0));
        if (in_v) begin
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=addr %0d required=no beat", wgt_addr);
          end else begin
            b = expq.pop_front();
            check("in_act", in_act, b.act);
            check("wgt_addr", wgt_addr, b.addr);
            check("vec_done", vec_done, b.done);
            if (b.done) pending--;
          end
          log_act.push_back(in_act);
          log_addr.push_back(wgt_addr);
          log_cyc.push_back(cyc);
        end else begin
          check("vec_done_idle", vec_done, 1'b0);
        end
        check("s_rdy", s_rdy, (pending < 2));
      end
    end
  end

  task automatic clear_logs();
    log_act.delete();
    log_addr.delete();
    log_cyc.delete();
    stall_cnt = 0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k = 0;
    while (log_act.size() < n && k < budget) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (log_act.size() < n) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout actual=%0d required=%0d", log_act.size(), n);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_v"}, in_v, 1'b0);
    check({tag, "_vec_done"}, vec_done, 1'b0);
    check({tag, "_wgt_addr"}, wgt_addr, '0);
    check({tag, "_in_act"}, in_act, '0);
    check({tag, "_s_rdy"}, s_rdy, 1'b1);
  endtask

  logic [7:0] lit1[4];
  logic [7:0] w8;

  initial begin
    lit1 = '{8'h10, 8'h32, 8'h54, 8'h76};

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Single vector, unstalled
    clear_logs();
    for (int i = 0; i < 4; i++) send_q.push_back(lit1[i]);
    wait_beats(8, 60);
    idle(6);
    check("single_count", log_act.size(), 8);
    for (int i = 0; i < 8 && i < log_act.size(); i++) begin
      check("single_act_lit", log_act[i], lit1[i % 4]);
      check("single_addr_lit", log_addr[i], i);
    end
    // Full flag set at the last write's edge, beat registered on the next one.
    if (log_cyc.size() > 0) check("first_beat_latency", log_cyc[0] - last_wr_cyc, 1);

    // Back-to-back: three vectors streamed with s_v held high
    clear_logs();
    for (int v = 0; v < 3; v++)
      for (int j = 0; j < 4; j++) begin
        w8 = 8'(8'hA0 + v * 16 + j);
        send_q.push_back(w8);
      end
    wait_beats(24, 120);
    idle(4);
    check("b2b_count", log_act.size(), 24);
    if (log_cyc.size() >= 24) check("b2b_contiguous", log_cyc[23] - log_cyc[0], 23);
    check("b2b_upstream_stalls", stall_cnt, 4);
    if (log_act.size() >= 24) begin
      check("b2b_v2_first", log_act[8], 8'hB0);
      check("b2b_v3_last", log_act[23], 8'hC3);
    end

    // Random downstream stalls
    clear_logs();
    or_pct = 50;
    for (int i = 0; i < 4; i++) send_q.push_back(lit1[i]);
    wait_beats(8, 400);
    or_pct = 100;
    idle(4);
    check("stall_count", log_act.size(), 8);
    for (int i = 0; i < 8 && i < log_act.size(); i++) begin
      check("stall_act_lit", log_act[i], lit1[i % 4]);
      check("stall_addr_lit", log_addr[i], i);
    end

    // Sparse upstream
    clear_logs();
    sv_pct = 30;
    for (int i = 0; i < 8; i++) begin
      w8 = 8'(8'h20 + 8'h11 * i);
      send_q.push_back(w8);
    end
    wait_beats(16, 600);
    sv_pct = 100;
    idle(4);
    check("gaps_count", log_act.size(), 16);
    if (log_act.size() >= 16) check("gaps_v2_first", log_act[8], 8'h64);

    // Reset in the middle of a replay
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      w8 = 8'(8'h90 + i);
      send_q.push_back(w8);
    end
    wait_beats(5, 60);
    #1;
    rst_n = 1'b0;
    send_q.delete();
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    check("midrst_no_more_beats", log_act.size(), 5);
    for (int i = 0; i < 4; i++) begin
      w8 = 8'(8'hE1 + i);
      send_q.push_back(w8);
    end
    wait_beats(13, 60);
    idle(4);
    check("midrst_total", log_act.size(), 13);
    if (log_act.size() >= 6) begin
      check("midrst_restart_addr", log_addr[5], 0);
      check("midrst_restart_act", log_act[5], 8'hE1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
